// File: rtl/lsu_pkg.sv
// Shared load/store types: access size, data-memory FSM states and the byte-lane mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    A0   = 2'b01,
    A1   = 2'b10,
    RD   = 2'b11
  } dmem_state_e;

  function automatic logic [3:0] size_mask(input mem_size_e s);
    case (s)
      BYTE:    return 4'h1;
      HALF:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts a two-word load window down to the access offset, truncates to size and extends.
module load_align
  import lsu_pkg::*;
(
  input  logic [63:0] words_i,
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        uns_i,
  output logic [31:0] rdata_o
);

  logic [63:0] sh;
  assign sh = words_i >> {off_i, 3'b000};

  always_comb begin
    rdata_o = sh[31:0];
    case (size_i)
      BYTE:    rdata_o = {{24{~uns_i & sh[7]}}, sh[7:0]};
      HALF:    rdata_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      default: rdata_o = sh[31:0];
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// Load/store initiator for a sync-read, byte-enable DRAM; splits word-crossing accesses into two beats.
module dmem_master
  import lsu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [AW-1:0] mem_a,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_spo
);

  dmem_state_e   state_q, state_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [3:0]    mem_we_q, mem_we_d, b1_we_q, b1_we_d;
  logic [31:0]   mem_din_q, mem_din_d, b1_din_q, b1_din_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d, word0_q, word0_d;
  logic          resp_valid_q, resp_valid_d;
  logic          we_q, we_d, split_q, split_d, uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  mem_size_e     size_q, size_d;

  mem_size_e   req_sz;
  logic [7:0]  m8;
  logic [63:0] w64;
  logic [31:0] ld_data;

  assign req_sz = (req_size == 2'b11) ? WORD : mem_size_e'(req_size);
  assign m8     = {4'h0, size_mask(req_sz)} << req_addr[1:0];
  assign w64    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};

  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;

  // In RD the DRAM output holds the last word read: word1 when split, else the only word.
  load_align u_align (
    .words_i (split_q ? {mem_spo, word0_q} : {32'h0, mem_spo}),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .rdata_o (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_a_d      = mem_a_q;
    mem_we_d     = mem_we_q;
    mem_din_d    = mem_din_q;
    b1_we_d      = b1_we_q;
    b1_din_d     = b1_din_q;
    resp_rdata_d = resp_rdata_q;
    word0_d      = word0_q;
    resp_valid_d = 1'b0;
    we_d         = we_q;
    split_d      = split_q;
    uns_d        = uns_q;
    off_d        = off_q;
    size_d       = size_q;
    case (state_q)
      IDLE: if (req_valid) begin
        mem_a_d   = req_addr[AW+1:2];
        mem_we_d  = req_we ? m8[3:0] : 4'h0;
        mem_din_d = w64[31:0];
        b1_we_d   = m8[7:4];
        b1_din_d  = w64[63:32];
        split_d   = |m8[7:4];
        we_d      = req_we;
        uns_d     = req_unsigned;
        off_d     = req_addr[1:0];
        size_d    = req_sz;
        state_d   = A0;
      end
      A0: begin
        if (split_q) begin
          mem_a_d   = mem_a_q + AW'(1);
          mem_we_d  = we_q ? b1_we_q : 4'h0;
          mem_din_d = b1_din_q;
          state_d   = A1;
        end else begin
          mem_we_d     = 4'h0;
          resp_valid_d = we_q;
          state_d      = we_q ? IDLE : RD;
        end
      end
      A1: begin
        if (!we_q) word0_d = mem_spo;
        mem_we_d     = 4'h0;
        resp_valid_d = we_q;
        state_d      = we_q ? IDLE : RD;
      end
      RD: begin
        resp_rdata_d = ld_data;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_a_q      <= '0;
      mem_we_q     <= 4'h0;
      mem_din_q    <= '0;
      b1_we_q      <= 4'h0;
      b1_din_q     <= '0;
      resp_rdata_q <= '0;
      word0_q      <= '0;
      resp_valid_q <= 1'b0;
      we_q         <= 1'b0;
      split_q      <= 1'b0;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= BYTE;
    end else begin
      state_q      <= state_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_din_q    <= mem_din_d;
      b1_we_q      <= b1_we_d;
      b1_din_q     <= b1_din_d;
      resp_rdata_q <= resp_rdata_d;
      word0_q      <= word0_d;
      resp_valid_q <= resp_valid_d;
      we_q         <= we_d;
      split_q      <= split_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      size_q       <= size_d;
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: DRAM model plus a byte-addressed reference memory.
module tb_dmem_master;
  localparam int AW = 16;
  localparam int NB = 1 << (AW + 2);

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          req_ready, resp_valid;
  logic [31:0]   resp_rdata, mem_din, mem_spo;
  logic [AW-1:0] mem_a;
  logic [3:0]    mem_we;
  logic          mem_clr = 1'b0;

  logic [31:0] dram [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:NB-1];
  int n_cmp = 0, n_err = 0, we_cnt = 0, rv_cnt = 0;

  dmem_master #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din),
    .mem_spo(mem_spo)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) dram[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) dram[mem_a][8*b +: 8] <= mem_din[8*b +: 8];
    end
    mem_spo <= dram[mem_a];
  end

  always @(negedge clk) begin
    if (mem_we != 4'h0) we_cnt++;
    if (resp_valid) rv_cnt++;
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int bidx(input logic [31:0] a);
    return int'(a[AW+1:0]);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    for (int i = 0; i < nbytes(size); i++) ref_mem[bidx(addr + i)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(size);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[bidx(addr + i)];
    if (!uns && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic int exp_lat(input logic we, input logic [31:0] addr, input logic [1:0] size);
    int split;
    split = ((int'(addr[1:0]) + nbytes(size)) > 4) ? 1 : 0;
    return (we ? 1 : 2) + split;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // ---------------- drivers ----------------
  // Returns one time unit after the accept edge.
  task automatic start(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) begin
        @(posedge clk); #1; ok = 1'b1;
      end else @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept: req_ready never seen for addr %h", addr);
    end
  endtask

  task automatic wait_resp(output int lat);
    bit got;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1; lat++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: no resp_valid within %0d edges", lat);
      lat = -1;
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat, output int wes);
    int w0;
    w0 = we_cnt;
    start(we, size, uns, addr, wd);
    wait_resp(lat);
    rd = resp_rdata;
    wes = we_cnt - w0;
    if (we) ref_store(addr, size, wd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); mem_clr = 1'b0; #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
    n_cmp++; if (mem_we !== 4'h0) begin n_err++; $display("FAIL rst_we: got %h exp 0", mem_we); end
    n_cmp++; if (mem_a !== '0) begin n_err++; $display("FAIL rst_a: got %h exp 0", mem_a); end
    n_cmp++; if (mem_din !== '0) begin n_err++; $display("FAIL rst_din: got %h exp 0", mem_din); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b exp 0", resp_valid); end
    n_cmp++; if (resp_rdata !== '0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", resp_rdata); end
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_word;
    int lat, wes; logic [31:0] rd;
    start(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (mem_a !== 16'h0010) begin n_err++; $display("FAIL word_a: got %h exp 0010", mem_a); end
    n_cmp++; if (mem_we !== 4'hF) begin n_err++; $display("FAIL word_we: got %b exp 1111", mem_we); end
    n_cmp++; if (mem_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_din: got %h exp deadbeef", mem_din); end
    wait_resp(lat);
    ref_store(32'h40, 2'b10, 32'hDEADBEEF);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL word_st_lat: got %0d exp 1", lat); end
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, lat, wes);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_ld: got %h exp deadbeef", rd); end
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL word_ld_lat: got %0d exp 2", lat); end
    n_cmp++; if (wes != 0) begin n_err++; $display("FAIL word_ld_we: got %0d write cycles exp 0", wes); end
  endtask

  task automatic test_byte;
    int lat, wes; logic [31:0] rd;
    start(1'b1, 2'b00, 1'b0, 32'h43, 32'h123456A5);
    n_cmp++; if (mem_we !== 4'b1000) begin n_err++; $display("FAIL byte_we: got %b exp 1000", mem_we); end
    n_cmp++; if (mem_din !== 32'hA5000000) begin n_err++; $display("FAIL byte_din: got %h exp a5000000", mem_din); end
    wait_resp(lat);
    ref_store(32'h43, 2'b00, 32'h123456A5);
    xact(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, rd, lat, wes);
    n_cmp++; if (rd !== 32'hFFFFFFA5) begin n_err++; $display("FAIL byte_sext: got %h exp ffffffa5", rd); end
    xact(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, rd, lat, wes);
    n_cmp++; if (rd !== 32'h000000A5) begin n_err++; $display("FAIL byte_zext: got %h exp 000000a5", rd); end
  endtask

  task automatic test_split;
    int lat, wes; logic [31:0] rd;
    start(1'b1, 2'b10, 1'b0, 32'h46, 32'h11223344);
    n_cmp++; if (mem_a !== 16'h0011) begin n_err++; $display("FAIL split_a0: got %h exp 0011", mem_a); end
    n_cmp++; if (mem_we !== 4'b1100) begin n_err++; $display("FAIL split_we0: got %b exp 1100", mem_we); end
    n_cmp++; if (mem_din !== 32'h33440000) begin n_err++; $display("FAIL split_din0: got %h exp 33440000", mem_din); end
    @(posedge clk); #1;
    n_cmp++; if (mem_a !== 16'h0012) begin n_err++; $display("FAIL split_a1: got %h exp 0012", mem_a); end
    n_cmp++; if (mem_we !== 4'b0011) begin n_err++; $display("FAIL split_we1: got %b exp 0011", mem_we); end
    n_cmp++; if (mem_din !== 32'h00001122) begin n_err++; $display("FAIL split_din1: got %h exp 00001122", mem_din); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL split_early_rv: got %b exp 0", resp_valid); end
    wait_resp(lat);
    ref_store(32'h46, 2'b10, 32'h11223344);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL split_st_lat: got %0d exp 2", lat + 1); end
    xact(1'b0, 2'b10, 1'b0, 32'h46, 32'h0, rd, lat, wes);
    n_cmp++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL split_ld: got %h exp 11223344", rd); end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL split_ld_lat: got %0d exp 3", lat); end
  endtask

  task automatic test_wrap;
    int lat, wes; logic [31:0] rd;
    start(1'b1, 2'b01, 1'b0, 32'h0003FFFF, 32'h0000BEEF);
    n_cmp++; if (mem_a !== 16'hFFFF) begin n_err++; $display("FAIL wrap_a0: got %h exp ffff", mem_a); end
    n_cmp++; if (mem_we !== 4'b1000) begin n_err++; $display("FAIL wrap_we0: got %b exp 1000", mem_we); end
    @(posedge clk); #1;
    n_cmp++; if (mem_a !== 16'h0000) begin n_err++; $display("FAIL wrap_a1: got %h exp 0000", mem_a); end
    n_cmp++; if (mem_we !== 4'b0001) begin n_err++; $display("FAIL wrap_we1: got %b exp 0001", mem_we); end
    wait_resp(lat);
    ref_store(32'h0003FFFF, 2'b01, 32'h0000BEEF);
    xact(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, rd, lat, wes);
    n_cmp++; if (rd !== ref_load(32'h0003FFFF, 2'b01, 1'b0)) begin n_err++; $display("FAIL wrap_ld: got %h exp %h", rd, ref_load(32'h0003FFFF, 2'b01, 1'b0)); end
  endtask

  task automatic test_reset_mid;
    int rv0;
    start(1'b1, 2'b10, 1'b0, 32'h46, 32'hCAFEF00D);
    rv0 = rv_cnt;
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (mem_we !== 4'h0) begin n_err++; $display("FAIL rstmid_we: got %b exp 0000", mem_we); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b exp 0", req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after: got %b exp 1", req_ready); end
    n_cmp++; if (rv_cnt != rv0) begin n_err++; $display("FAIL rstmid_resp: got %0d responses exp 0", rv_cnt - rv0); end
    n_cmp++; if (dram[16'h0011] !== ref_word(16'h0011)) begin n_err++; $display("FAIL rstmid_w11: got %h exp %h", dram[16'h0011], ref_word(16'h0011)); end
    n_cmp++; if (dram[16'h0012] !== ref_word(16'h0012)) begin n_err++; $display("FAIL rstmid_w12: got %h exp %h", dram[16'h0012], ref_word(16'h0012)); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] e1, e2;
    e1 = ref_load(32'h40, 2'b10, 1'b0);
    e2 = ref_load(32'h46, 2'b01, 1'b1);
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_size = 2'b01; req_unsigned = 1'b1; req_addr = 32'h46;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_a0: got %b exp 0", req_ready); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_rd: got %b exp 0", req_ready); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_overlap: got rv=%b rdy=%b exp 1/1", resp_valid, req_ready); end
    n_cmp++; if (resp_rdata !== e1) begin n_err++; $display("FAIL b2b_data1: got %h exp %h", resp_rdata, e1); end
    @(posedge clk); #1; req_valid = 1'b0;
    wait_resp(lat);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL b2b_lat2: got %0d exp 2", lat); end
    n_cmp++; if (resp_rdata !== e2) begin n_err++; $display("FAIL b2b_data2: got %h exp %h", resp_rdata, e2); end
  endtask

  task automatic test_random;
    int lat, wes, el;
    logic [31:0] rd, addr, wd, exp_rd;
    logic we, uns;
    logic [1:0] size;
    for (int n = 0; n < 80; n++) begin
      we   = (n < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 31)) + (($urandom_range(0, 1) == 1) ? 32'h200 : 32'h3FFF0);
      addr = addr | ($urandom << 18);
      wd   = $urandom;
      exp_rd = ref_load(addr, size, uns);
      el = exp_lat(we, addr, size);
      xact(we, size, uns, addr, wd, rd, lat, wes);
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL rnd_lat[%0d]: got %0d exp %0d addr %h sz %0d we %b", n, lat, el, addr, size, we); end
      if (!we) begin
        n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_ld[%0d]: got %h exp %h addr %h sz %0d uns %b", n, rd, exp_rd, addr, size, uns); end
        n_cmp++; if (wes != 0) begin n_err++; $display("FAIL rnd_ld_we[%0d]: got %0d write cycles exp 0", n, wes); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    mem_clr = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
# dmem_master

Data-memory initiator sitting between the core's load/store stage and the synchronous-read, byte-write-enable DRAM model. It accepts one load/store request at a time over a valid/ready handshake and generates the DRAM word address, byte write enables and write data. For loads it collects the read word(s), aligns them and sign- or zero-extends the result. Accesses that cross a 32-bit word boundary are split into two DRAM beats.

## Interface
Parameters:
- `AW`, 16, DRAM word-address width. Byte address bits [AW+1:2] select the word.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`. Equals `rst_n && state==IDLE`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_unsigned`  in  1  load zero-extend (1) or sign-extend (0).
- `req_addr`  in  32  byte address. Bits [31:AW+2] are ignored.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse. For a load, the data is ready; for a store, the last beat has been written.
- `resp_rdata`  out  32  extended load data. Holds its value until the next load response.
- `mem_a`  out  AW  DRAM word address (registered).
- `mem_we`  out  4  DRAM byte write enables (registered).
- `mem_din`  out  32  DRAM write data (registered).
- `mem_spo`  in  32  DRAM read data. Valid one edge after `mem_a` is sampled.

## Operation
- `off = req_addr[1:0]`.
- Byte mask: `m8 = size_mask << off`, where size_mask is 0x1, 0x3 or 0xF.
- Write data: `w64 = {32'b0, req_wdata} << (8*off)`.
- Beat 0 uses word `W = req_addr[AW+1:2]`, enables `m8[3:0]`, data `w64[31:0]`.
- Beat 1 uses word `W+1` (modulo 2^AW), enables `m8[7:4]`, data `w64[63:32]`.
- The access is split iff `m8[7:4] != 0`.
- Load result: take `{word1, word0} >> (8*off)`, truncate to the access size, then extend. For an unsplit load, word1 is don't-care.
- `mem_we` is 0 in every cycle that is not a store beat. Loads never assert `mem_we`.
- FSM states and transitions:
  - IDLE: on accept, register beat 0 into `mem_*` and go to A0.
  - A0 (DRAM acts on beat 0 at the end of this cycle):
    - Split: register beat 1 and go to A1.
    - Unsplit store: `mem_we<=0`, `resp_valid<=1`, go to IDLE.
    - Unsplit load: `mem_we<=0`, go to RD.
  - A1: load captures `mem_spo` as word0. Then `mem_we<=0`. A store pulses `resp_valid` and goes to IDLE; a load goes to RD.
  - RD: assemble from `mem_spo` (plus word0 if split), register `resp_rdata`, `resp_valid<=1`, go to IDLE.

## Timing
- Let E0 be the accept edge.
- Latency, in edges from E0 to the edge that raises `resp_valid`:
  - Unsplit store: 1 (E1).
  - Split store: 2.
  - Unsplit load: 2.
  - Split load: 3.
- `resp_valid` is high during the IDLE cycle that follows. A new request may be accepted in that same cycle, which gives back-to-back throughput.
- `req_ready` is low in A0, A1 and RD. Requests held during these states stay pending; none are dropped.
- Reset values: state IDLE, `mem_a` 0, `mem_we` 0, `mem_din` 0, `resp_valid` 0, `resp_rdata` 0. `req_ready` is 0 while `rst_n` is low.
- Reset mid-operation: `mem_we` clears asynchronously, so no DRAM write occurs at the next edge. A pending beat 1 is never issued and no response is produced.
- Word-address wrap: beat 1 of word 2^AW−1 goes to word 0.

## Structure
- Shared package `lsu_pkg` contains:
  - `mem_size_e` (BYTE, HALF, WORD).
  - `dmem_state_e` (IDLE, A0, A1, RD).
  - Function `size_mask(mem_size_e)`.
- Sub-module `load_align` is purely combinational: it takes {word1, word0}, off, size and unsigned, and returns the 32-bit extended result.
- FSM, beat registers and word0 buffer live in `dmem_master`.

## Test plan
1. **Aligned word store then load:** store 0xDEADBEEF at 0x40 → one cycle with `mem_a`=0x0010, `mem_we`=1111, `mem_din`=0xDEADBEEF; `resp_valid` at E1. Load word at 0x40 → `resp_rdata`=0xDEADBEEF at E2.
2. **Byte store and extension:** store byte 0xA5 at 0x43 → `mem_we`=1000, `mem_din`=0xA5000000. Signed byte load from 0x43 → 0xFFFFFFA5; unsigned → 0x000000A5.
3. **Split word store then load:** store 0x11223344 at 0x46 → beat 0: `mem_a`=0x0011, `we`=1100, `din`=0x33440000; beat 1: `mem_a`=0x0012, `we`=0011, `din`=0x00001122. Word load at 0x46 → 0x11223344 at E3.
4. **Wrap-around:** store half 0xBEEF at byte 0x3FFFF → beat 0: `mem_a`=0xFFFF, `we`=1000; beat 1: `mem_a`=0x0000, `we`=0001.
5. **Reset mid split store:** drop `rst_n` during A0 → `mem_we` goes to 0 immediately; word 0x0012 is unchanged; no `resp_valid`; `req_ready`=1 after release.
6. **Back-to-back:** hold `req_valid` for two loads → `req_ready` is low in A0/RD; the second request is accepted in the cycle where `resp_valid` is high for the first.
